// File: rtl/dino_pkg.sv
// Shared definitions for the player-side blocks of the runner game.
//   player_state_t : 3-bit player state code seen by the renderer and
//                    game-over logic.
//   TICK_VEL/TICK_POS : bit indices into the two-phase game_tick bus.
package dino_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    JUMP = 3'd2,
    DUCK = 3'd3,
    DEAD = 3'd4
  } player_state_t;

  // game_tick[TICK_VEL] pulses first in a frame, game_tick[TICK_POS] on the
  // following cycle.
  localparam int TICK_VEL = 0;
  localparam int TICK_POS = 1;

endpackage

// File: rtl/button_conditioner.sv
// Button conditioner: 2-FF synchronizer, frame-tick debouncer and rise
// detect for one asynchronous active-high button.
//   clk, reset : system clock, synchronous active-high reset
//   tick       : frame pulse; the debouncer only advances on this cycle
//   raw        : asynchronous button input
//   level      : debounced level (registered)
//   press      : high in the tick cycle where level is about to go 0->1
module button_conditioner #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  logic          accept;

  // cnt counts consecutive ticks on which the synchronized level differs
  // from the accepted level; the tick that completes the run accepts it.
  assign accept = tick && (sync_b != level) &&
                  (cnt == CW'(DEBOUNCE_FRAMES - 1));

  // press is combinational so the consumer sees it in the same tick cycle
  // in which the registered level flips.
  assign press = accept && sync_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (tick) begin
        if (sync_b == level) begin
          cnt <= '0;
        end else if (accept) begin
          level <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/player_controller.sv
// Player-input and state sequencer feeding player_physics.
//   clk, reset    : system clock, synchronous active-high reset
//   game_tick[1:0]: [0] velocity-phase frame pulse, [1] position-phase pulse
//   btn_jump_raw  : asynchronous jump button
//   btn_down_raw  : asynchronous down button
//   jump_done     : from physics, meaningful on game_tick[1]
//   collision     : level from collision block, sampled on game_tick[1]
//   jump_pulse    : one-cycle jump request, only ever on game_tick[0]
//   button_down   : conditioned down level while RUN/DUCK/JUMP
//   player_state  : current state code (registered; also the FSM debug view)
//   anim_frame    : run/duck animation phase
//   game_over     : high while DEAD
// There is no handshake here: every request is a tick-qualified pulse or
// level that physics samples on its own phase, with no backpressure.
module player_controller
  import dino_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int ANIM_FRAMES     = 6,
  parameter int RESTART_HOLDOFF = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] game_tick,
  input  logic       btn_jump_raw,
  input  logic       btn_down_raw,
  input  logic       jump_done,
  input  logic       collision,
  output logic       jump_pulse,
  output logic       button_down,
  output logic [2:0] player_state,
  output logic       anim_frame,
  output logic       game_over
);

  localparam int AW = $clog2(ANIM_FRAMES + 1);
  localparam int HW = $clog2(RESTART_HOLDOFF + 1);

  player_state_t state, state_next;
  logic          tick_vel, tick_pos;
  logic          jump_level, jump_press;
  logic          down_level, down_press;
  logic          down_now;
  logic [AW-1:0] anim_cnt;
  logic [HW-1:0] holdoff;
  logic          holdoff_done;

  assign tick_vel = game_tick[TICK_VEL];
  assign tick_pos = game_tick[TICK_POS];

  button_conditioner #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_jump (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_vel),
    .raw   (btn_jump_raw),
    .level (jump_level),
    .press (jump_press)
  );

  button_conditioner #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_down (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_vel),
    .raw   (btn_down_raw),
    .level (down_level),
    .press (down_press)
  );

  // Down as it stands in this tick, including a rise accepted right now, so
  // that jump and down raised together resolve to DUCK with no jump_pulse.
  assign down_now     = down_level || down_press;
  assign holdoff_done = (holdoff == HW'(RESTART_HOLDOFF));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    jump_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick_vel && jump_press) state_next = RUN;
      end
      RUN: begin
        if (tick_pos && collision) begin
          state_next = DEAD;
        end else if (tick_vel && down_now) begin
          state_next = DUCK;
        end else if (tick_vel && jump_press) begin
          state_next = JUMP;
          jump_pulse = 1'b1;
        end
      end
      JUMP: begin
        if (tick_pos && collision)      state_next = DEAD;
        else if (tick_pos && jump_done) state_next = RUN;
      end
      DUCK: begin
        if (tick_pos && collision)      state_next = DEAD;
        else if (tick_vel && !down_now) state_next = RUN;
      end
      DEAD: begin
        if (tick_vel && jump_press && holdoff_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Holdoff clears whenever not DEAD, so it starts from 0 on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != DEAD) begin
      holdoff <= '0;
    end else if (tick_vel && !holdoff_done) begin
      holdoff <= holdoff + 1'b1;
    end
  end

  // Animation advances in RUN/DUCK, freezes in JUMP, clears in IDLE/DEAD.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || state == DEAD) begin
      anim_cnt   <= '0;
      anim_frame <= 1'b0;
    end else if ((state == RUN || state == DUCK) && tick_vel) begin
      if (anim_cnt == AW'(ANIM_FRAMES - 1)) begin
        anim_cnt   <= '0;
        anim_frame <= ~anim_frame;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  assign button_down  = down_level &&
                        (state == RUN || state == DUCK || state == JUMP);
  assign player_state = state;
  assign game_over    = (state == DEAD);

endmodule

// File: tb/tb_player_controller.sv
module tb_player_controller;
  import dino_pkg::*;

  localparam int FRAME = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] game_tick;
  logic       btn_jump_raw, btn_down_raw, jump_done, collision;
  logic       jump_pulse, button_down, anim_frame, game_over;
  logic [2:0] player_state;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  int row_pulses = 0;
  logic [2:0] seen_state = IDLE;

  typedef struct {
    logic       jump;
    logic       down;
    logic       done;
    logic       coll;
    int         frames;
    logic [2:0] st;
    logic       bd;
    logic       go;
    int         pulses;
  } vec_t;

  vec_t vecs[19];
  logic [12:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  player_controller dut (
    .clk          (clk),
    .reset        (reset),
    .game_tick    (game_tick),
    .btn_jump_raw (btn_jump_raw),
    .btn_down_raw (btn_down_raw),
    .jump_done    (jump_done),
    .collision    (collision),
    .jump_pulse   (jump_pulse),
    .button_down  (button_down),
    .player_state (player_state),
    .anim_frame   (anim_frame),
    .game_over    (game_over)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // driver: one clock; drives the tick bus at negedge, samples #1 later
  task automatic step();
    logic [1:0] prev_tick;
    logic       prev_reset;
    @(negedge clk);
    prev_tick  = game_tick;
    prev_reset = reset;
    if (player_state != seen_state) begin
      chk("state_change_on_tick", {31'd0, (prev_tick != 2'b00) || prev_reset}, 32'd1);
    end
    game_tick = (phase == 0) ? 2'b01 : (phase == 1) ? 2'b10 : 2'b00;
    phase = (phase + 1) % FRAME;
    #1;
    if (jump_pulse === 1'b1) begin
      row_pulses++;
      chk("pulse_on_tick_vel", {31'd0, game_tick[0]}, 32'd1);
    end
    seen_state = player_state;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) step();
  endtask

  task automatic sync_phase(input int p);
    int guard = 0;
    while (phase != p && guard < FRAME) begin
      step();
      guard++;
    end
  endtask

  initial begin
    logic [12:0] exp;
    logic        a0;
    int          n;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0,   5, RUN,  1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0,   4, RUN,  1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,   3, JUMP, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,  10, JUMP, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1, RUN,  1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0,   4, DUCK, 1'b1, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0,   4, RUN,  1'b0, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,   3, JUMP, 1'b0, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0,   4, JUMP, 1'b1, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0,   3, JUMP, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1,   1, DEAD, 1'b0, 1'b1, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0,   8, DEAD, 1'b0, 1'b1, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0,   3, DEAD, 1'b0, 1'b1, 0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0,  25, DEAD, 1'b0, 1'b1, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0,   3, IDLE, 1'b0, 1'b0, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0,   3, IDLE, 1'b0, 1'b0, 0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0,   3, RUN,  1'b0, 1'b0, 0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0,   3, RUN,  1'b0, 1'b0, 0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 100, RUN,  1'b0, 1'b0, 1};

    reset = 1'b1;
    game_tick = 2'b00;
    btn_jump_raw = 1'b0;
    btn_down_raw = 1'b0;
    jump_done = 1'b0;
    collision = 1'b0;
    repeat (3) step();

    chk("reset_state",       {29'd0, player_state}, {29'd0, IDLE});
    chk("reset_jump_pulse",  {31'd0, jump_pulse},  32'd0);
    chk("reset_button_down", {31'd0, button_down}, 32'd0);
    chk("reset_anim_frame",  {31'd0, anim_frame},  32'd0);
    chk("reset_game_over",   {31'd0, game_over},   32'd0);
    reset = 1'b0;

    // table-driven rows with scoreboard queue
    for (int i = 0; i < 19; i++) begin
      sync_phase(4);
      btn_jump_raw = vecs[i].jump;
      btn_down_raw = vecs[i].down;
      jump_done    = vecs[i].done;
      collision    = vecs[i].coll;
      row_pulses   = 0;
      exp_q.push_back({vecs[i].st, vecs[i].bd, vecs[i].go, 8'(vecs[i].pulses)});
      run_frames(vecs[i].frames);
      exp = exp_q.pop_front();
      chk($sformatf("row%0d {state,bd,go,pulses}", i),
          {19'd0, player_state, button_down, game_over, 8'(row_pulses)},
          {19'd0, exp});
      if (i == 15) chk("idle_anim_clear", {31'd0, anim_frame}, 32'd0);
    end

    // animation period in RUN
    btn_jump_raw = 1'b0;
    jump_done    = 1'b0;
    a0 = anim_frame;
    n = 0;
    while (anim_frame == a0 && n < 100) begin step(); n++; end
    chk("anim_first_toggle_seen", {31'd0, n < 100}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      a0 = anim_frame;
      n = 0;
      while (anim_frame == a0 && n < 200) begin step(); n++; end
      chk($sformatf("anim_period%0d_cycles", k), n, 6 * FRAME);
    end

    // one-cycle glitches at every frame phase
    run_frames(3);
    row_pulses = 0;
    for (int g = 0; g < FRAME; g++) begin
      btn_jump_raw = 1'b1;
      step();
      btn_jump_raw = 1'b0;
      repeat (FRAME) step();
    end
    run_frames(3);
    chk("glitch_pulses", row_pulses, 0);
    chk("glitch_state", {29'd0, player_state}, {29'd0, RUN});

    // reset in the middle of a jump with fast-drop active
    sync_phase(4);
    btn_jump_raw = 1'b1;
    row_pulses = 0;
    run_frames(3);
    chk("prereset_state", {29'd0, player_state}, {29'd0, JUMP});
    chk("prereset_pulses", row_pulses, 1);
    btn_down_raw = 1'b1;
    run_frames(3);
    chk("prereset_fast_drop", {31'd0, button_down}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midjump_reset_state",       {29'd0, player_state}, {29'd0, IDLE});
    chk("midjump_reset_jump_pulse",  {31'd0, jump_pulse},  32'd0);
    chk("midjump_reset_button_down", {31'd0, button_down}, 32'd0);
    chk("midjump_reset_anim_frame",  {31'd0, anim_frame},  32'd0);
    chk("midjump_reset_game_over",   {31'd0, game_over},   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
